multiplier_seq: RTL and testbench
=================================

Name: multiplier_seq

Overview:
- Multi-cycle shift-and-add integer multiplier; the inverse-operation companion to the team's sequential divider in the ALU.
- One multiplier bit is processed per clock. It uses the same start/ready handshake as the divider, so the ALU sequencer drives both blocks identically.
- Produces a full 2*WIDTH-bit product, split into hi/lo words, plus an overflow flag for ALU ops that keep only the low word.

Parameters:
- WIDTH, 32, operand width in bits; legal values 2..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; accepted only when ready=1
- multiplicand  input  WIDTH  operand A; sampled on the accept edge only
- multiplier  input  WIDTH  operand B; sampled on the accept edge only
- product_hi  output  WIDTH  upper word of product
- product_lo  output  WIDTH  lower word of product
- overflow  output  1  product does not fit in WIDTH bits (see Behaviour)
- ready  output  1  idle; can accept start
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Interface timing: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: ready=1, done=0, product_hi=0, product_lo=0, overflow=0, bit counter=0, state=IDLE.
- States:
  - IDLE: ready=1.
  - RUN: ready=0.
- IDLE->RUN on a rising edge with start=1 and reset=0. That edge is the accept edge, T0.
  - Operands are latched on the accept edge.
  - Accumulator is loaded {WIDTH'0, multiplier}.
  - Counter is loaded with WIDTH.
  - ready drops after T0.
- RUN step, one per edge:
  - If acc[0]=1, add multiplicand to acc[2W-1:W] with carry-out kept as bit 2W.
  - Shift the (2W+1)-bit value right by 1; the result becomes acc[2W-1:0].
  - Counter decrements by 1.
- RUN->IDLE on the edge where the counter goes 1->0, which is edge T0+WIDTH.
  - On that edge, product_hi/product_lo/overflow update from the final accumulator.
  - ready=1 and done=1 for exactly the following cycle.
- Latency: ready is low for exactly WIDTH cycles. done is asserted in the same cycle ready returns high.
- Outputs hold their last result until the next completion. They are not cleared on accept, and are cleared only by reset.
- start while ready=0 is ignored and is not queued. Operand changes during RUN have no effect.
- start=1 in the done cycle is a legal back-to-back accept:
  - done still pulses for one cycle only.
  - ready drops on the next edge.
- Unsigned mode overflow = (product_hi != 0).
- Counter width: $clog2(WIDTH+1) bits. No other arithmetic wraps; the carry bit prevents loss on the add.
- Zero operand: still takes WIDTH cycles. No early-out.
- Reset priority:
  - reset=1 with start=1: reset wins; no accept.
  - Reset during RUN: aborts; next cycle is IDLE, ready=1, done=0, outputs=0.
  - No done pulse is generated for an aborted operation.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), sampled on the accept edge.
  - With signed_op=1, operands are two's complement: magnitudes are multiplied by the same RUN engine. The sign flag (A[W-1]^B[W-1]) is latched at accept.
  - On completion the 2W-bit result is negated if the sign flag is set. The negation happens in the same completion edge, so latency is unchanged at WIDTH cycles.
  - Most-negative operands (e.g. 0x80000000) are handled; magnitude 2^(W-1) fits in W bits unsigned.
  - Signed overflow = product_hi is not all copies of product_lo[W-1].
  - With signed_op=0, behaviour is identical to the unsigned mode.
- Not defined: port signed_op is absent; unsigned only.

Test Plan:
- Basic multiply, WIDTH=32: reset, then start with 7*6.
  - ready low exactly 32 cycles.
  - done pulses once.
  - product_hi=0, product_lo=42, overflow=0.
- Maximum operands: 0xFFFFFFFF*0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001, overflow=1.
- Start while busy / operand change:
  - Accept 3*5; pulse start with 9*9 and change operands at cycle 10 of RUN.
  - Result is 15, a single done pulse, and no second operation.
- Reset mid-operation and reset priority:
  - Start 0x12345678*0x10; assert reset at cycle 5. Next cycle: ready=1, outputs 0, no done.
  - Then start+reset together: ready stays 1.
- Back-to-back and zero operand:
  - Start 0*0xDEADBEEF; assert start in its done cycle with 0x10000*0x10000.
  - First result is 0 after 32 cycles. Second result is product_hi=1, product_lo=0, overflow=1 after 32 more cycles.
- MUL_SIGNED_EN defined:
  - signed_op=1, -3*5 -> product_hi=0xFFFFFFFF, product_lo=0xFFFFFFF1, overflow=0.
  - 0x80000000*0x80000000 -> product_hi=0x40000000, product_lo=0, overflow=1.

Source files
------------

// File: rtl/multiplier_seq.sv
// multiplier_seq: WIDTH-cycle shift-and-add multiplier with start/ready/done handshake; `define MUL_SIGNED_EN adds signed_op.
module multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
`ifdef MUL_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             overflow,
  output logic             ready,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [2*WIDTH-1:0] acc, step, prod;
  logic [WIDTH-1:0] mcand, a_mag, b_mag;
  logic [WIDTH:0] sum;
  logic [CW-1:0] cnt;
  logic accept, finish, ovf;
`ifdef MUL_SIGNED_EN
  logic neg_a, neg_b, sign_q, signed_q;
  always_comb begin
    neg_a = signed_op & multiplicand[WIDTH-1];
    neg_b = signed_op & multiplier[WIDTH-1];
    a_mag = neg_a ? -multiplicand : multiplicand;
    b_mag = neg_b ? -multiplier : multiplier;
    prod = sign_q ? -step : step;
    ovf = signed_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}}) : (prod[2*WIDTH-1:WIDTH] != '0);
  end
  always_ff @(posedge clk)
    if (reset) begin
      sign_q <= 1'b0;
      signed_q <= 1'b0;
    end else if (accept) begin
      sign_q <= neg_a ^ neg_b;
      signed_q <= signed_op;
    end
`else
  always_comb begin
    a_mag = multiplicand;
    b_mag = multiplier;
    prod = step;
    ovf = prod[2*WIDTH-1:WIDTH] != '0;
  end
`endif
  // carry of the add lands in sum[WIDTH] and is shifted back into the top bit
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : '0};
    step = {sum, acc[WIDTH-1:1]};
    accept = (state == IDLE) && start;
    finish = (state == RUN) && (cnt == CW'(1));
    ready = state == IDLE;
    state_next = accept ? RUN : finish ? IDLE : state;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  always_ff @(posedge clk)
    if (reset) begin
      acc <= '0;
      mcand <= '0;
      cnt <= '0;
      product_hi <= '0;
      product_lo <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        mcand <= a_mag;
        acc <= {{WIDTH{1'b0}}, b_mag};
        cnt <= CW'(WIDTH);
      end else if (state == RUN) begin
        acc <= step;
        cnt <= cnt - CW'(1);
        if (finish) begin
          product_hi <= prod[2*WIDTH-1:WIDTH];
          product_lo <= prod[WIDTH-1:0];
          overflow <= ovf;
        end
      end
    end
endmodule

// File: tb/tb_multiplier_seq.sv
// tb_multiplier_seq: directed table plus handshake corner sequences for multiplier_seq (WIDTH=32).
module tb_multiplier_seq;
  localparam int W = 32;
  logic clk = 1'b0, reset, start;
  logic [W-1:0] multiplicand, multiplier, product_hi, product_lo;
  logic overflow, ready, done;
`ifdef MUL_SIGNED_EN
  logic signed_op = 1'b0;
`endif
  int total = 0, bad = 0, done_cnt = 0, lowcnt, d0;
  logic [W-1:0] prev_hi = '0, prev_lo = '0;
  typedef struct {
    logic [W-1:0] a, b, hi, lo;
    logic ovf;
  } vec_t;
  vec_t vecs[7];

  multiplier_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
`ifdef MUL_SIGNED_EN
    .signed_op(signed_op),
`endif
    .product_hi(product_hi), .product_lo(product_lo),
    .overflow(overflow), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge with ready=1; returns at the negedge where ready is back
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_ready", {63'b0, ready}, 64'd0);
    chk("busy_done", {63'b0, done}, 64'd0);
    chk("held_hi", {32'b0, product_hi}, {32'b0, prev_hi});
    chk("held_lo", {32'b0, product_lo}, {32'b0, prev_lo});
    lowcnt = 0;
    while (!ready && lowcnt < 200) begin
      lowcnt++;
      if (inject && lowcnt == 10) begin
        start = 1'b1;
        multiplicand = 32'd9;
        multiplier = 32'd9;
      end else if (inject && lowcnt == 11) begin
        start = 1'b0;
        multiplicand = 32'hAAAA_5555;
        multiplier = 32'h1234_0000;
      end
      @(negedge clk);
    end
    chk("latency", 64'(lowcnt), 64'(W));
    chk("done_pulse", {63'b0, done}, 64'd1);
  endtask

  task automatic expect_res(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo, input logic ovf);
    chk({name, "_hi"}, {32'b0, product_hi}, {32'b0, hi});
    chk({name, "_lo"}, {32'b0, product_lo}, {32'b0, lo});
    chk({name, "_ovf"}, {63'b0, overflow}, {63'b0, ovf});
    prev_hi = hi;
    prev_lo = lo;
  endtask

  initial begin
    vecs[0] = '{a: 32'd7,         b: 32'd6,         hi: 32'd0,         lo: 32'd42,        ovf: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, ovf: 1'b1};
    vecs[2] = '{a: 32'd1,         b: 32'hFFFF_FFFF, hi: 32'd0,         lo: 32'hFFFF_FFFF, ovf: 1'b0};
    vecs[3] = '{a: 32'h8000_0000, b: 32'd2,         hi: 32'd1,         lo: 32'd0,         ovf: 1'b1};
    vecs[4] = '{a: 32'h1234_5678, b: 32'h10,        hi: 32'd1,         lo: 32'h2345_6780, ovf: 1'b1};
    vecs[5] = '{a: 32'h0000_FFFF, b: 32'h0000_FFFF, hi: 32'd0,         lo: 32'hFFFE_0001, ovf: 1'b0};
    vecs[6] = '{a: 32'hDEAD_BEEF, b: 32'd0,         hi: 32'd0,         lo: 32'd0,         ovf: 1'b0};
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {63'b0, ready}, 64'd1);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, product_hi}, 64'd0);
    chk("rst_lo", {32'b0, product_lo}, 64'd0);
    chk("rst_ovf", {63'b0, overflow}, 64'd0);
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b, 1'b0);
      expect_res($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].ovf);
      @(negedge clk);
      chk("done_one_cycle", {63'b0, done}, 64'd0);
    end
    d0 = done_cnt;
    issue(32'd3, 32'd5, 1'b1);
    expect_res("busy", 32'd0, 32'd15, 1'b0);
    repeat (40) @(negedge clk);
    chk("busy_no_second", 64'(done_cnt), 64'(d0 + 1));
    chk("busy_idle", {63'b0, ready}, 64'd1);
    chk("busy_hold_lo", {32'b0, product_lo}, 64'd15);
    start = 1'b1;
    multiplicand = 32'h1234_5678;
    multiplier = 32'h10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {63'b0, ready}, 64'd1);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_hi", {32'b0, product_hi}, 64'd0);
    chk("abort_lo", {32'b0, product_lo}, 64'd0);
    chk("abort_ovf", {63'b0, overflow}, 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    start = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    chk("rst_prio_ready", {63'b0, ready}, 64'd1);
    @(negedge clk);
    chk("rst_prio_still", {63'b0, ready}, 64'd1);
    issue(32'd0, 32'hDEAD_BEEF, 1'b0);
    expect_res("zero", 32'd0, 32'd0, 1'b0);
    issue(32'h0001_0000, 32'h0001_0000, 1'b0);
    expect_res("b2b", 32'd1, 32'd0, 1'b1);
    @(negedge clk);
`ifdef MUL_SIGNED_EN
    signed_op = 1'b1;
    issue(-32'sd3, 32'd5, 1'b0);
    expect_res("sneg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    @(negedge clk);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    expect_res("smin", 32'h4000_0000, 32'd0, 1'b1);
    @(negedge clk);
    signed_op = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
